// File: rtl/accel_pkg.sv
// Shared types and constants for the matrix-multiply DMA sequencer.
// Tile-count helper is shared so every user rounds partial tiles the same way.
package accel_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_REQ,
      S_XFER,
      S_NEXT,
      S_DONE
   } state_t;

   localparam int unsigned ELEM_BYTES    = 4;
   localparam int unsigned BEAT_BITS     = 256;
   localparam int unsigned DEFAULT_SIZE  = 8;
   localparam int unsigned BEATS_PER_ROW = DEFAULT_SIZE / 8;

   // Widened to 33 bits so dimensions near 2^32 do not wrap while rounding up.
   function automatic logic [31:0] ceil_div(input logic [31:0] x, input logic [31:0] d);
      logic [32:0] w_sum;
      w_sum = {1'b0, x} + {1'b0, d} - 33'd1;
      return 32'(w_sum / {1'b0, d});
   endfunction

endpackage

// File: rtl/accel_addr_gen.sv
// Combinational byte address of one tile row of A or B for the given tile
// coordinates, storage mode and matrix dimensions (32-bit wrap-around).
module accel_addr_gen
   import accel_pkg::*;
#(
   parameter int unsigned SIZE = 8
) (
   input  logic [31:0] i_ti,
   input  logic [31:0] i_tj,
   input  logic [31:0] i_tk,
   input  logic [31:0] i_row,
   input  logic        i_phase_b,
   input  logic        i_a_mode,
   input  logic        i_b_mode,
   input  logic [31:0] i_base_a,
   input  logic [31:0] i_base_b,
   input  logic [31:0] i_m,
   input  logic [31:0] i_k,
   input  logic [31:0] i_n,
   output logic [31:0] o_addr
);

   logic [31:0] w_base;
   logic [31:0] w_row_idx;
   logic [31:0] w_stride;
   logic [31:0] w_col_idx;

   // NOTE: every signal gets a default before the branches so no latch can be inferred.
   always_comb begin
      w_base    = i_base_a;
      w_row_idx = '0;
      w_stride  = '0;
      w_col_idx = '0;
      if (!i_phase_b) begin
         w_base = i_base_a;
         if (i_a_mode) begin
            w_row_idx = i_ti * 32'(SIZE) + i_row;
            w_stride  = i_k;
            w_col_idx = i_tk * 32'(SIZE);
         end else begin
            w_row_idx = i_tk * 32'(SIZE) + i_row;
            w_stride  = i_m;
            w_col_idx = i_ti * 32'(SIZE);
         end
      end else begin
         w_base = i_base_b;
         if (i_b_mode) begin
            w_row_idx = i_tk * 32'(SIZE) + i_row;
            w_stride  = i_n;
            w_col_idx = i_tj * 32'(SIZE);
         end else begin
            w_row_idx = i_tj * 32'(SIZE) + i_row;
            w_stride  = i_k;
            w_col_idx = i_tk * 32'(SIZE);
         end
      end
   end

   assign o_addr = w_base + (w_row_idx * w_stride + w_col_idx) * ELEM_BYTES;

endmodule

// File: rtl/accel_control_register.sv
// Tiled matmul sequencer: walks (i, j, kk) tiles, issues one DMA per A/B tile
// row and forwards accepted beats to the systolic-array input buffers.
module accel_control_register
   import accel_pkg::*;
#(
   parameter int unsigned SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [31:0]          addr_base_a,
   input  logic [31:0]          addr_base_b,
   input  logic [31:0]          m,
   input  logic [31:0]          k,
   input  logic [31:0]          n,
   input  logic                 a_in_mode,
   input  logic                 b_in_mode,
   input  logic                 start,
   output logic                 dma_start,
   output logic [31:0]          dma_addr,
   input  logic                 dma_valid,
   input  logic                 dma_ready,
   input  logic                 dma_done,
   input  logic [BEAT_BITS-1:0] dma_data,
   output logic [BEAT_BITS-1:0] buf_data_in,
   output logic                 read_a,
   output logic                 read_b,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned      R_W      = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam logic [R_W-1:0]   ROW_LAST = R_W'(SIZE - 1);

   state_t                r_state;
   logic [31:0]           r_base_a, r_base_b, r_m, r_k, r_n;
   logic                  r_a_mode, r_b_mode;
   logic [31:0]           r_tm, r_tk, r_tn;
   logic [31:0]           r_ti, r_tj, r_tkk;
   logic [R_W-1:0]        r_row;
   logic                  r_phase_b;
   logic                  r_dma_start, r_read_a, r_read_b, r_busy, r_done;
   logic [31:0]           r_dma_addr;
   logic [BEAT_BITS-1:0]  r_buf_data;

   logic [31:0]           w_ti_nxt, w_tj_nxt, w_tkk_nxt;
   logic [R_W-1:0]        w_row_nxt;
   logic                  w_phase_nxt, w_last;
   logic [31:0]           w_next_addr;

   // Row counter is innermost, then A->B phase, then kk, j, i.
   always_comb begin
      w_row_nxt   = r_row;
      w_phase_nxt = r_phase_b;
      w_tkk_nxt   = r_tkk;
      w_tj_nxt    = r_tj;
      w_ti_nxt    = r_ti;
      w_last      = 1'b0;
      if (r_row != ROW_LAST) begin
         w_row_nxt = r_row + 1'b1;
      end else begin
         w_row_nxt   = '0;
         w_phase_nxt = ~r_phase_b;
         if (r_phase_b) begin
            if (r_tkk != r_tk - 32'd1) begin
               w_tkk_nxt = r_tkk + 32'd1;
            end else begin
               w_tkk_nxt = '0;
               if (r_tj != r_tn - 32'd1) begin
                  w_tj_nxt = r_tj + 32'd1;
               end else begin
                  w_tj_nxt = '0;
                  if (r_ti != r_tm - 32'd1) w_ti_nxt = r_ti + 32'd1;
                  else                      w_last   = 1'b1;
               end
            end
         end
      end
   end

   accel_addr_gen #(.SIZE(SIZE)) u_addr_gen (
      .i_ti      (w_ti_nxt),
      .i_tj      (w_tj_nxt),
      .i_tk      (w_tkk_nxt),
      .i_row     (32'(w_row_nxt)),
      .i_phase_b (w_phase_nxt),
      .i_a_mode  (r_a_mode),
      .i_b_mode  (r_b_mode),
      .i_base_a  (r_base_a),
      .i_base_b  (r_base_b),
      .i_m       (r_m),
      .i_k       (r_k),
      .i_n       (r_n),
      .o_addr    (w_next_addr)
   );

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_base_a    <= '0;
         r_base_b    <= '0;
         r_m         <= '0;
         r_k         <= '0;
         r_n         <= '0;
         r_a_mode    <= 1'b0;
         r_b_mode    <= 1'b0;
         r_tm        <= '0;
         r_tk        <= '0;
         r_tn        <= '0;
         r_ti        <= '0;
         r_tj        <= '0;
         r_tkk       <= '0;
         r_row       <= '0;
         r_phase_b   <= 1'b0;
         r_dma_start <= 1'b0;
         r_dma_addr  <= '0;
         r_read_a    <= 1'b0;
         r_read_b    <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         // NOTE: the wide data register is reset too, because it drives an output that must read 0 out of reset.
         r_buf_data  <= '0;
      end else begin
         r_dma_start <= 1'b0;
         r_done      <= 1'b0;
         r_read_a    <= 1'b0;
         r_read_b    <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_LATCH;
                  r_busy  <= 1'b1;
               end
            end
            S_LATCH: begin
               r_base_a  <= addr_base_a;
               r_base_b  <= addr_base_b;
               r_m       <= m;
               r_k       <= k;
               r_n       <= n;
               r_a_mode  <= a_in_mode;
               r_b_mode  <= b_in_mode;
               r_tm      <= ceil_div(m, 32'(SIZE));
               r_tk      <= ceil_div(k, 32'(SIZE));
               r_tn      <= ceil_div(n, 32'(SIZE));
               r_ti      <= '0;
               r_tj      <= '0;
               r_tkk     <= '0;
               r_row     <= '0;
               r_phase_b <= 1'b0;
               // Tile (0,0,0) A row 0 reduces to the A base in either storage mode.
               r_dma_addr <= addr_base_a;
               if (m == '0 || k == '0 || n == '0) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state     <= S_REQ;
                  r_dma_start <= 1'b1;
               end
            end
            S_REQ: r_state <= S_XFER;
            S_XFER: begin
               if (dma_valid && dma_ready) begin
                  r_buf_data <= dma_data;
                  r_read_a   <= ~r_phase_b;
                  r_read_b   <= r_phase_b;
               end
               if (dma_done) r_state <= S_NEXT;
            end
            S_NEXT: begin
               r_ti      <= w_ti_nxt;
               r_tj      <= w_tj_nxt;
               r_tkk     <= w_tkk_nxt;
               r_row     <= w_row_nxt;
               r_phase_b <= w_phase_nxt;
               if (w_last) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state     <= S_REQ;
                  r_dma_start <= 1'b1;
                  r_dma_addr  <= w_next_addr;
               end
            end
            S_DONE: begin
               if (!start) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign dma_start   = r_dma_start;
   assign dma_addr    = r_dma_addr;
   assign buf_data_in = r_buf_data;
   assign read_a      = r_read_a;
   assign read_b      = r_read_b;
   assign busy        = r_busy;
   assign done        = r_done;

endmodule

// File: tb/tb_accel_control_register.sv
// Bench for accel_control_register: directed jobs plus randomized DMA handshakes,
// checked against a row-address list derived directly from the tiling formulas.
module tb_accel_control_register;
   import accel_pkg::*;

   localparam int unsigned SIZE = 8;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic [31:0]          addr_base_a, addr_base_b, m, k, n;
   logic                 a_in_mode, b_in_mode, start;
   logic                 dma_start;
   logic [31:0]          dma_addr;
   logic                 dma_valid, dma_ready, dma_done;
   logic [BEAT_BITS-1:0] dma_data;
   logic [BEAT_BITS-1:0] buf_data_in;
   logic                 read_a, read_b, busy, done;

   int checks = 0;
   int failures = 0;
   int n_start_pulses = 0, n_read_a = 0, n_read_b = 0, n_done = 0, n_both = 0;

   logic [31:0] exp_addr_q[$];
   bit          exp_a_q[$];

   accel_control_register #(.SIZE(SIZE)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .addr_base_a (addr_base_a),
      .addr_base_b (addr_base_b),
      .m           (m),
      .k           (k),
      .n           (n),
      .a_in_mode   (a_in_mode),
      .b_in_mode   (b_in_mode),
      .start       (start),
      .dma_start   (dma_start),
      .dma_addr    (dma_addr),
      .dma_valid   (dma_valid),
      .dma_ready   (dma_ready),
      .dma_done    (dma_done),
      .dma_data    (dma_data),
      .buf_data_in (buf_data_in),
      .read_a      (read_a),
      .read_b      (read_b),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (dma_start)         n_start_pulses++;
      if (read_a)            n_read_a++;
      if (read_b)            n_read_b++;
      if (done)              n_done++;
      if (read_a && read_b)  n_both++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] rand256();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Expected row sequence: i, j, kk tile loops, then SIZE A rows and SIZE B rows.
   task automatic build_model(input logic [31:0] mm, input logic [31:0] kd, input logic [31:0] nn,
                              input logic [31:0] ba, input logic [31:0] bb,
                              input logic am, input logic bmode);
      int tm, tk, tn;
      logic [31:0] s, ii, jj, qq, rr;
      exp_addr_q.delete();
      exp_a_q.delete();
      if (mm == 0 || kd == 0 || nn == 0) return;
      s  = SIZE;
      tm = int'((64'(mm) + SIZE - 1) / SIZE);
      tk = int'((64'(kd) + SIZE - 1) / SIZE);
      tn = int'((64'(nn) + SIZE - 1) / SIZE);
      for (int i = 0; i < tm; i++)
         for (int j = 0; j < tn; j++)
            for (int q = 0; q < tk; q++)
               for (int ph = 0; ph < 2; ph++)
                  for (int r = 0; r < SIZE; r++) begin
                     ii = i; jj = j; qq = q; rr = r;
                     if (ph == 0) begin
                        exp_addr_q.push_back(am ? ba + ((ii*s + rr)*kd + qq*s)*4
                                                : ba + ((qq*s + rr)*mm + ii*s)*4);
                        exp_a_q.push_back(1'b1);
                     end else begin
                        exp_addr_q.push_back(bmode ? bb + ((qq*s + rr)*nn + jj*s)*4
                                                   : bb + ((jj*s + rr)*kd + qq*s)*4);
                        exp_a_q.push_back(1'b0);
                     end
                  end
   endtask

   // proto 0: one beat with dma_done per row; proto 1: random beats, stalls and lone dma_done.
   task automatic run_job(input string name, input logic [31:0] jm, input logic [31:0] jk,
                          input logic [31:0] jn, input logic [31:0] ba, input logic [31:0] bb,
                          input logic am, input logic bmode, input int proto,
                          input logic [255:0] first_data);
      int s0, ra0, rb0, d0, b0, nb, tries, n_rows, exp_ra;
      bit alone, acc, v, rd;
      logic [255:0] data;
      s0 = n_start_pulses; ra0 = n_read_a; rb0 = n_read_b; d0 = n_done; b0 = n_both;
      build_model(jm, jk, jn, ba, bb, am, bmode);
      n_rows = exp_addr_q.size();
      exp_ra = 0;
      foreach (exp_a_q[x]) if (exp_a_q[x]) exp_ra++;
      m = jm; k = jk; n = jn; addr_base_a = ba; addr_base_b = bb;
      a_in_mode = am; b_in_mode = bmode;
      start = 1'b1;
      step();
      check({name, "_busy_latch"}, busy, 1);
      step();
      m = $urandom; k = $urandom; n = $urandom;
      addr_base_a = $urandom; addr_base_b = $urandom;
      a_in_mode = 1'($urandom); b_in_mode = 1'($urandom);
      if (n_rows == 0) begin
         check({name, "_zero_done"}, done, 1);
         check({name, "_zero_no_start"}, dma_start, 0);
      end else begin
         for (int row = 0; row < n_rows; row++) begin
            check($sformatf("%s_r%0d_start", name, row), dma_start, 1);
            check($sformatf("%s_r%0d_addr", name, row), dma_addr, exp_addr_q[row]);
            if (proto != 0) begin
               dma_valid = 1'b1; dma_ready = 1'b1; dma_data = rand256();
            end
            step();
            dma_valid = 1'b0; dma_ready = 1'b0;
            check($sformatf("%s_r%0d_xfer_nostart", name, row), dma_start, 0);
            if (proto != 0)
               check($sformatf("%s_r%0d_req_ignored", name, row), {read_a, read_b}, 2'b00);
            nb    = (proto != 0) ? $urandom_range(0, 2 * BEATS_PER_ROW) : 1;
            alone = (nb == 0) || ((proto != 0) && ($urandom_range(0, 1) == 1));
            for (int b = 0; b < nb; b++) begin
               data  = (row == 0 && b == 0) ? first_data : rand256();
               tries = 0;
               acc   = 1'b0;
               while (!acc) begin
                  if (proto == 0 || tries >= 8) begin
                     v = 1'b1; rd = 1'b1;
                  end else begin
                     v  = ($urandom_range(0, 3) != 0);
                     rd = ($urandom_range(0, 3) != 0);
                  end
                  acc       = v && rd;
                  dma_data  = data;
                  dma_valid = v;
                  dma_ready = rd;
                  dma_done  = acc && (b == nb - 1) && !alone;
                  tries++;
                  step();
                  if (!acc)
                     check($sformatf("%s_r%0d_stall", name, row), {read_a, read_b}, 2'b00);
               end
               dma_valid = 1'b0; dma_ready = 1'b0; dma_done = 1'b0;
               check($sformatf("%s_r%0d_b%0d_data", name, row, b), buf_data_in, data);
               check($sformatf("%s_r%0d_b%0d_rda", name, row, b), read_a, exp_a_q[row]);
               check($sformatf("%s_r%0d_b%0d_rdb", name, row, b), read_b, !exp_a_q[row]);
            end
            if (alone) begin
               dma_done  = 1'b1;
               dma_valid = 1'($urandom);
               dma_ready = 1'b0;
               step();
               dma_done = 1'b0; dma_valid = 1'b0;
               check($sformatf("%s_r%0d_lone_done", name, row), {read_a, read_b}, 2'b00);
            end
            check($sformatf("%s_r%0d_next_nostart", name, row), dma_start, 0);
            step();
         end
         check({name, "_done_pulse"}, done, 1);
      end
      repeat (3) begin
         step();
         check({name, "_hold_done_low"}, done, 0);
         check({name, "_hold_busy"}, busy, 1);
         check({name, "_hold_no_restart"}, dma_start, 0);
      end
      start = 1'b0;
      step();
      check({name, "_idle_busy"}, busy, 0);
      check({name, "_start_count"}, n_start_pulses - s0, n_rows);
      check({name, "_read_a_count"}, n_read_a - ra0, (proto == 0) ? exp_ra : n_read_a - ra0);
      check({name, "_read_b_count"}, n_read_b - rb0, (proto == 0) ? n_rows - exp_ra : n_read_b - rb0);
      check({name, "_done_count"}, n_done - d0, 1);
      check({name, "_no_overlap"}, n_both - b0, 0);
   endtask

   initial begin
      rstn = 1'b0; start = 1'b0;
      m = '0; k = '0; n = '0; addr_base_a = '0; addr_base_b = '0;
      a_in_mode = 1'b0; b_in_mode = 1'b0;
      dma_valid = 1'b0; dma_ready = 1'b0; dma_done = 1'b0; dma_data = '0;
      step();
      step();
      check("rst_outputs", {dma_start, dma_addr, read_a, read_b, busy, done}, '0);
      check("rst_buf", buf_data_in, '0);
      rstn = 1'b1;
      step();

      run_job("base16", 32'd16, 32'd16, 32'd16, 32'h1000_0010, 32'h2000_0100,
              1'b1, 1'b1, 0, 256'h1234_5678);
      run_job("restart", 32'd16, 32'd16, 32'd16, 32'h1000_0010, 32'h2000_0100,
              1'b1, 1'b1, 0, rand256());
      run_job("zero_m", 32'd0, 32'd16, 32'd16, 32'h3000_0000, 32'h4000_0000,
              1'b1, 1'b1, 0, '0);
      run_job("a_mode0", 32'd8, 32'd16, 32'd8, 32'h0000_4000, 32'h0000_8000,
              1'b0, 1'b1, 1, rand256());

      // Reset in the middle of a transfer, after a beat has been forwarded.
      m = 32'd16; k = 32'd16; n = 32'd16;
      addr_base_a = 32'h5555_0000; addr_base_b = 32'h6666_0000;
      a_in_mode = 1'b1; b_in_mode = 1'b1;
      start = 1'b1;
      step();
      step();
      step();
      dma_valid = 1'b1; dma_ready = 1'b1; dma_data = rand256();
      step();
      dma_valid = 1'b0; dma_ready = 1'b0;
      check("abort_pre_read_a", read_a, 1);
      #2;
      rstn  = 1'b0;
      start = 1'b0;
      #1;
      check("abort_outputs", {dma_start, dma_addr, read_a, read_b, busy, done}, '0);
      check("abort_buf", buf_data_in, '0);
      step();
      rstn = 1'b1;
      step();
      run_job("after_abort", 32'd16, 32'd8, 32'd16, 32'h7000_0040, 32'h7100_0000,
              1'b1, 1'b0, 1, rand256());

      for (int t = 0; t < 3; t++)
         run_job($sformatf("rand%0d", t), 32'($urandom_range(1, 20)), 32'($urandom_range(1, 20)),
                 32'($urandom_range(1, 20)), $urandom, $urandom,
                 1'($urandom), 1'($urandom), 1, rand256());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
